// File: rtl/eio_pkg.sv
// eio_pkg: shared EIO slave handshake states, timer register offsets and size codes.
package eio_pkg;
    typedef enum logic [1:0] {IDLE, ACK, DRAIN} EIO_STATE;
    localparam logic [5:0] TMR_MTIME_LO = 6'h00;
    localparam logic [5:0] TMR_MTIME_HI = 6'h04;
    localparam logic [5:0] TMR_CMP_LO   = 6'h08;
    localparam logic [5:0] TMR_CMP_HI   = 6'h0C;
    localparam logic [5:0] TMR_CTRL     = 6'h10;
    localparam logic [1:0] EIO_SIZE_WORD = 2'd2;
endpackage

// File: rtl/eio_slave_fsm.sv
// eio_slave_fsm: generic EIO request/ack/drain handshake; accept pulses when a request is taken.
module eio_slave_fsm
    import eio_pkg::*;
(
    input  logic clk_in,
    input  logic reset_in,
    input  logic req,
    output logic accept,
    output logic ack
);
    EIO_STATE state, state_nxt;
    always_ff @(posedge clk_in) begin
        if (reset_in) state <= IDLE;
        else          state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (req ? ACK : IDLE) : state == ACK ? DRAIN : IDLE;
        accept = state == IDLE && req;
        ack = state == ACK;
    end
endmodule

// File: rtl/eio_timer.sv
// eio_timer: EIO machine timer (mtime, mtimecmp, ctrl) with level interrupt.
// Optional EIO_TIMER_PRESCALE_EN adds an 8-bit prescaler in ctrl[15:8].
module eio_timer
    import eio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          A_SZ      = 32,
    parameter int          RSZ       = 32
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            eio_req,
    input  logic            eio_rw,
    input  logic [A_SZ-1:0] eio_addr,
    input  logic [1:0]      eio_size,
    input  logic [RSZ-1:0]  eio_wr_data,
    output logic            eio_ack,
    output logic            eio_ack_fault,
    output logic [RSZ-1:0]  eio_ack_data,
    output logic            timer_irq
);
    logic        accept, fault, wr, rd, en, tick, fault_q;
    logic [5:0]  off;
    logic [31:0] wdata, rd_val, ctrl_val, hi_shadow, data_q;
    logic [63:0] mtime, mtime_inc, mtime_nxt, mtimecmp;

    eio_slave_fsm u_fsm (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .req     (eio_req),
        .accept  (accept),
        .ack     (eio_ack)
    );

    assign off   = eio_addr[5:0];
    assign wdata = eio_wr_data[31:0];
    assign fault = eio_addr[A_SZ-1:6] != BASE_ADDR[A_SZ-1:6] || off > TMR_CTRL
                   || eio_size != EIO_SIZE_WORD || eio_addr[1:0] != 2'b00;
    assign wr    = accept && eio_rw && !fault;
    assign rd    = accept && !eio_rw && !fault;

`ifdef EIO_TIMER_PRESCALE_EN
    logic [7:0] presc, pcnt;
    assign ctrl_val = {16'h0, presc, 7'h0, en};
    assign tick     = en && pcnt == presc;
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (wr && off == TMR_CTRL) begin
            presc <= wdata[15:8];
            pcnt  <= '0;
        end else if (en) begin
            pcnt  <= tick ? 8'h0 : pcnt + 8'h1;
        end
    end
`else
    assign ctrl_val = {31'h0, en};
    assign tick     = en;
`endif

    // A half written this cycle overrides the increment and blocks the carry into the other half.
    always_comb begin
        mtime_inc = mtime + 64'h1;
        mtime_nxt = tick ? mtime_inc : mtime;
        mtime_nxt = wr && off == TMR_MTIME_LO ? {mtime[63:32], wdata} : mtime_nxt;
        mtime_nxt = wr && off == TMR_MTIME_HI ? {wdata, mtime_nxt[31:0]} : mtime_nxt;
        rd_val = off == TMR_MTIME_LO ? mtime[31:0] :
                 off == TMR_MTIME_HI ? hi_shadow :
                 off == TMR_CMP_LO   ? mtimecmp[31:0] :
                 off == TMR_CMP_HI   ? mtimecmp[63:32] :
                 off == TMR_CTRL     ? ctrl_val : 32'h0;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            en        <= 1'b0;
            hi_shadow <= '0;
            timer_irq <= 1'b0;
            data_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            timer_irq <= mtime >= mtimecmp;
            if (wr && off == TMR_CMP_LO)   mtimecmp[31:0]  <= wdata;
            if (wr && off == TMR_CMP_HI)   mtimecmp[63:32] <= wdata;
            if (wr && off == TMR_CTRL)     en              <= wdata[0];
            if (rd && off == TMR_MTIME_LO) hi_shadow       <= mtime[63:32];
            if (accept) begin
                data_q  <= rd ? rd_val : 32'h0;
                fault_q <= fault;
            end
        end
    end

    assign eio_ack_fault = eio_ack && fault_q;
    assign eio_ack_data  = eio_ack ? RSZ'(data_q) : '0;
endmodule
